// File: rtl/wb_stage.sv
// Writeback stage: one-entry pipeline register between the memory stage and the
// register file, with load alignment/extension, forwarding tap and retire counter.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ms_valid_i,
    output logic            ms_ready_o,
    input  logic [XLEN-1:0] ms_pc_i,
    input  logic [4:0]      ms_rd_i,
    input  logic            ms_rf_we_i,
    input  logic            ms_is_load_i,
    input  logic [2:0]      ms_load_op_i,
    input  logic [XLEN-1:0] ms_alu_res_i,
    input  logic [XLEN-1:0] ms_mem_rdata_i,
    input  logic            commit_stall_i,
    output logic [4:0]      reg_dst_o,
    output logic            reg_wen_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            fwd_valid_o,
    output logic [4:0]      fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o,
    output logic            retire_o,
    output logic [XLEN-1:0] retire_pc_o,
    output logic [63:0]     instret_o,
    output logic            load_err_o
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_we;
    logic [XLEN-1:0] r_data;
    logic            r_err;
    logic [63:0]     r_instret;

    logic            w_fire;
    logic            w_capture;
    logic            w_writes_rd;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_err;
    logic [XLEN-1:0] w_cap_data;
    logic            w_cap_err;

    assign w_fire      = r_valid & ~commit_stall_i;
    assign ms_ready_o  = ~r_valid | ~commit_stall_i;
    assign w_capture   = ms_valid_i & ms_ready_o;
    assign w_writes_rd = r_we & (r_rd != 5'd0);

    // Load alignment and extension, evaluated on the offered instruction at capture time
    always_comb begin
        w_byte      = 8'd0;
        w_half      = 16'd0;
        w_load_data = {XLEN{1'b0}};
        w_load_err  = 1'b0;
        case (ms_alu_res_i[1:0])
            2'd0:    w_byte = ms_mem_rdata_i[7:0];
            2'd1:    w_byte = ms_mem_rdata_i[15:8];
            2'd2:    w_byte = ms_mem_rdata_i[23:16];
            2'd3:    w_byte = ms_mem_rdata_i[31:24];
            default: w_byte = 8'd0;
        endcase
        if (ms_alu_res_i[1]) begin
            w_half = ms_mem_rdata_i[31:16];
        end else begin
            w_half = ms_mem_rdata_i[15:0];
        end
        case (ms_load_op_i)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd2:    w_load_data = ms_mem_rdata_i;
            3'd4:    w_load_data = {24'd0, w_byte};
            3'd5:    w_load_data = {16'd0, w_half};
            default: begin
                w_load_data = {XLEN{1'b0}};
                w_load_err  = 1'b1;
            end
        endcase
        if (ms_is_load_i) begin
            w_cap_data = w_load_data;
            w_cap_err  = w_load_err;
        end else begin
            w_cap_data = ms_alu_res_i;
            w_cap_err  = 1'b0;
        end
    end

    // Pipeline entry: capture wins over fire so accept-while-retiring leaves no bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_pc    <= {XLEN{1'b0}};
            r_rd    <= 5'd0;
            r_we    <= 1'b0;
            r_data  <= {XLEN{1'b0}};
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_pc    <= ms_pc_i;
            r_rd    <= ms_rd_i;
            r_we    <= ms_rf_we_i;
            r_data  <= w_cap_data;
            r_err   <= w_cap_err;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_instret <= 64'd0;
        end else if (w_fire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign reg_wen_o   = w_fire & w_writes_rd;
    assign reg_dst_o   = r_rd;
    assign reg_wdata_o = r_data;
    assign fwd_valid_o = r_valid & w_writes_rd;
    assign fwd_rd_o    = r_rd;
    assign fwd_data_o  = r_data;
    assign retire_o    = w_fire;
    assign retire_pc_o = r_pc;
    assign instret_o   = r_instret;
    assign load_err_o  = r_valid & r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ms_valid_i;
    logic        ms_ready_o;
    logic [31:0] ms_pc_i;
    logic [4:0]  ms_rd_i;
    logic        ms_rf_we_i;
    logic        ms_is_load_i;
    logic [2:0]  ms_load_op_i;
    logic [31:0] ms_alu_res_i;
    logic [31:0] ms_mem_rdata_i;
    logic        commit_stall_i;
    logic [4:0]  reg_dst_o;
    logic        reg_wen_o;
    logic [31:0] reg_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        retire_o;
    logic [31:0] retire_pc_o;
    logic [63:0] instret_o;
    logic        load_err_o;

    int checks = 0;
    int errors = 0;
    longint unsigned exp_instret = 64'd0;

    wb_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ms_valid_i(ms_valid_i), .ms_ready_o(ms_ready_o),
        .ms_pc_i(ms_pc_i), .ms_rd_i(ms_rd_i), .ms_rf_we_i(ms_rf_we_i),
        .ms_is_load_i(ms_is_load_i), .ms_load_op_i(ms_load_op_i),
        .ms_alu_res_i(ms_alu_res_i), .ms_mem_rdata_i(ms_mem_rdata_i),
        .commit_stall_i(commit_stall_i),
        .reg_dst_o(reg_dst_o), .reg_wen_o(reg_wen_o), .reg_wdata_o(reg_wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
        .retire_o(retire_o), .retire_pc_o(retire_pc_o),
        .instret_o(instret_o), .load_err_o(load_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic offer(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic ld, input logic [2:0] op,
                         input logic [31:0] alu, input logic [31:0] rdata);
        ms_valid_i     = v;
        ms_pc_i        = pc;
        ms_rd_i        = rd;
        ms_rf_we_i     = we;
        ms_is_load_i   = ld;
        ms_load_op_i   = op;
        ms_alu_res_i   = alu;
        ms_mem_rdata_i = rdata;
    endtask

    task automatic idle();
        offer(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        commit_stall_i = 1'b0;
        idle();
        #12;
        checks++; if (ms_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ms_ready_o); end
        checks++; if (reg_wen_o !== 1'b0 || retire_o !== 1'b0 || fwd_valid_o !== 1'b0 || load_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got wen=%b ret=%b fwd=%b err=%b exp 0", reg_wen_o, retire_o, fwd_valid_o, load_err_o); end
        checks++; if (instret_o !== 64'd0 || reg_wdata_o !== 32'd0 || reg_dst_o !== 5'd0 || retire_pc_o !== 32'd0) begin
            errors++; $display("FAIL reset_values got instret=%0d data=%h dst=%0d pc=%h exp 0", instret_o, reg_wdata_o, reg_dst_o, retire_pc_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        logic [4:0]  rds [3];
        logic [31:0] vals[3];
        rds[0] = 5'd5;  rds[1] = 5'd6;  rds[2] = 5'd7;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) offer(1'b1, 32'h100 + 32'(i * 4), rds[i], 1'b1, 1'b0, 3'd0, vals[i], 32'd0);
            else idle();
            #1;
            checks++; if (ms_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, ms_ready_o); end
            if (i > 0) begin
                checks++; if (reg_wen_o !== 1'b1 || reg_dst_o !== rds[i-1] || reg_wdata_o !== vals[i-1]) begin
                    errors++; $display("FAIL b2b_write[%0d] got wen=%b dst=%0d data=%h exp 1 %0d %h", i, reg_wen_o, reg_dst_o, reg_wdata_o, rds[i-1], vals[i-1]); end
                checks++; if (retire_pc_o !== 32'h100 + 32'((i - 1) * 4)) begin
                    errors++; $display("FAIL b2b_pc[%0d] got %h exp %h", i, retire_pc_o, 32'h100 + 32'((i - 1) * 4)); end
            end
            @(negedge clk_i);
        end
        exp_instret += 3;
        #1;
        checks++; if (reg_wen_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_wen got %b exp 0", reg_wen_o); end
        checks++; if (instret_o !== 64'd3) begin errors++; $display("FAIL b2b_instret got %0d exp 3", instret_o); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  ops [6];
        logic [31:0] adrs[6];
        logic [31:0] exps[6];
        ops[0] = 3'd0; adrs[0] = 32'h1000; exps[0] = 32'hFFFF_FF82;
        ops[1] = 3'd4; adrs[1] = 32'h1000; exps[1] = 32'h0000_0082;
        ops[2] = 3'd0; adrs[2] = 32'h1001; exps[2] = 32'h0000_007F;
        ops[3] = 3'd1; adrs[3] = 32'h1002; exps[3] = 32'hFFFF_80F1;
        ops[4] = 3'd5; adrs[4] = 32'h1002; exps[4] = 32'h0000_80F1;
        ops[5] = 3'd2; adrs[5] = 32'h1000; exps[5] = 32'h80F1_7F82;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            offer(1'b1, 32'h200, 5'd10, 1'b1, 1'b1, ops[i], adrs[i], 32'h80F1_7F82);
            @(negedge clk_i);
            idle();
            #1;
            checks++; if (reg_wen_o !== 1'b1 || reg_wdata_o !== exps[i] || load_err_o !== 1'b0) begin
                errors++; $display("FAIL load[%0d] got wen=%b data=%h err=%b exp 1 %h 0", i, reg_wen_o, reg_wdata_o, load_err_o, exps[i]); end
            exp_instret += 1;
        end
    endtask

    task automatic test_x0_nowrite();
        @(negedge clk_i);
        offer(1'b1, 32'h300, 5'd0, 1'b1, 1'b0, 3'd0, 32'hAAAA, 32'd0);
        @(negedge clk_i);
        offer(1'b1, 32'h304, 5'd3, 1'b0, 1'b0, 3'd0, 32'hBBBB, 32'd0);
        #1;
        checks++; if (reg_wen_o !== 1'b0 || fwd_valid_o !== 1'b0 || retire_o !== 1'b1 || retire_pc_o !== 32'h300) begin
            errors++; $display("FAIL x0_entry got wen=%b fwd=%b ret=%b pc=%h exp 0 0 1 300", reg_wen_o, fwd_valid_o, retire_o, retire_pc_o); end
        @(negedge clk_i);
        idle();
        #1;
        checks++; if (reg_wen_o !== 1'b0 || fwd_valid_o !== 1'b0 || retire_o !== 1'b1 || retire_pc_o !== 32'h304) begin
            errors++; $display("FAIL nowe_entry got wen=%b fwd=%b ret=%b pc=%h exp 0 0 1 304", reg_wen_o, fwd_valid_o, retire_o, retire_pc_o); end
        @(negedge clk_i);
        #1;
        exp_instret += 2;
        checks++; if (retire_o !== 1'b0 || instret_o !== exp_instret) begin
            errors++; $display("FAIL x0_after got ret=%b instret=%0d exp 0 %0d", retire_o, instret_o, exp_instret); end
    endtask

    task automatic test_stall();
        @(negedge clk_i);
        offer(1'b1, 32'h400, 5'd9, 1'b1, 1'b0, 3'd0, 32'hDEAD, 32'd0);
        @(negedge clk_i);
        offer(1'b1, 32'h404, 5'd11, 1'b1, 1'b0, 3'd0, 32'hBEEF, 32'd0);
        commit_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ms_ready_o !== 1'b0 || reg_wen_o !== 1'b0 || retire_o !== 1'b0) begin
                errors++; $display("FAIL stall[%0d] got ready=%b wen=%b ret=%b exp 0 0 0", i, ms_ready_o, reg_wen_o, retire_o); end
            checks++; if (fwd_valid_o !== 1'b1 || fwd_rd_o !== 5'd9 || fwd_data_o !== 32'hDEAD || instret_o !== exp_instret) begin
                errors++; $display("FAIL stall_fwd[%0d] got fwd=%b rd=%0d data=%h instret=%0d exp 1 9 dead %0d", i, fwd_valid_o, fwd_rd_o, fwd_data_o, instret_o, exp_instret); end
            @(negedge clk_i);
        end
        commit_stall_i = 1'b0;
        #1;
        checks++; if (reg_wen_o !== 1'b1 || reg_dst_o !== 5'd9 || reg_wdata_o !== 32'hDEAD || ms_ready_o !== 1'b1) begin
            errors++; $display("FAIL stall_release got wen=%b dst=%0d data=%h ready=%b exp 1 9 dead 1", reg_wen_o, reg_dst_o, reg_wdata_o, ms_ready_o); end
        @(negedge clk_i);
        idle();
        exp_instret += 1;
        #1;
        checks++; if (instret_o !== exp_instret || reg_dst_o !== 5'd11 || reg_wdata_o !== 32'hBEEF || reg_wen_o !== 1'b1) begin
            errors++; $display("FAIL stall_next got instret=%0d dst=%0d data=%h wen=%b exp %0d 11 beef 1", instret_o, reg_dst_o, reg_wdata_o, reg_wen_o, exp_instret); end
        @(negedge clk_i);
        exp_instret += 1;
    endtask

    task automatic test_illegal_load();
        offer(1'b1, 32'h500, 5'd4, 1'b1, 1'b1, 3'd3, 32'h1000, 32'hFFFF_FFFF);
        @(negedge clk_i);
        idle();
        #1;
        checks++; if (load_err_o !== 1'b1 || reg_wen_o !== 1'b1 || reg_dst_o !== 5'd4 || reg_wdata_o !== 32'd0 || retire_o !== 1'b1) begin
            errors++; $display("FAIL illegal_load got err=%b wen=%b dst=%0d data=%h ret=%b exp 1 1 4 0 1", load_err_o, reg_wen_o, reg_dst_o, reg_wdata_o, retire_o); end
        @(negedge clk_i);
        exp_instret += 1;
        #1;
        checks++; if (load_err_o !== 1'b0 || instret_o !== exp_instret) begin
            errors++; $display("FAIL illegal_after got err=%b instret=%0d exp 0 %0d", load_err_o, instret_o, exp_instret); end
    endtask

    task automatic test_async_reset();
        bit saw_x8 = 1'b0;
        @(negedge clk_i);
        offer(1'b1, 32'h600, 5'd8, 1'b1, 1'b0, 3'd0, 32'h55, 32'd0);
        @(negedge clk_i);
        idle();
        commit_stall_i = 1'b1;
        #1;
        checks++; if (fwd_valid_o !== 1'b1 || fwd_data_o !== 32'h55) begin
            errors++; $display("FAIL areset_held got fwd=%b data=%h exp 1 55", fwd_valid_o, fwd_data_o); end
        #1;
        rst_i = 1'b1;
        #1;
        checks++; if (fwd_valid_o !== 1'b0 || fwd_data_o !== 32'd0 || reg_wen_o !== 1'b0 || ms_ready_o !== 1'b1 || instret_o !== 64'd0 || retire_pc_o !== 32'd0) begin
            errors++; $display("FAIL areset_clear got fwd=%b data=%h wen=%b ready=%b instret=%0d pc=%h exp 0 0 0 1 0 0", fwd_valid_o, fwd_data_o, reg_wen_o, ms_ready_o, instret_o, retire_pc_o); end
        @(negedge clk_i);
        commit_stall_i = 1'b0;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (reg_wen_o === 1'b1 && reg_dst_o === 5'd8) saw_x8 = 1'b1;
            @(negedge clk_i);
        end
        checks++; if (saw_x8 !== 1'b0 || instret_o !== 64'd0) begin
            errors++; $display("FAIL areset_after got x8write=%b instret=%0d exp 0 0", saw_x8, instret_o); end
        offer(1'b1, 32'h700, 5'd12, 1'b1, 1'b0, 3'd0, 32'h77, 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        checks++; if (reg_wen_o !== 1'b1 || reg_dst_o !== 5'd12 || reg_wdata_o !== 32'h77) begin
            errors++; $display("FAIL areset_resume got wen=%b dst=%0d data=%h exp 1 12 77", reg_wen_o, reg_dst_o, reg_wdata_o); end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_extend();
        test_x0_nowrite();
        test_stall();
        test_illegal_load();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
